i2c_slave_regfile: RTL and testbench
====================================

// Module: i2c_slave_regfile
// PURPOSE
// Register bank directly behind the I2C slave byte engine. Consumes received bytes
// (datareceive/received) and produces the byte to transmit (datasend), advancing on sended.
// First data byte after a start is the register pointer; later bytes write registers with
// pointer auto-increment. Reads stream registers from the pointer. Host-side port for user logic.
// PARAMETERS
// ADDR_W   4        pointer/address width; REG_COUNT = 2**ADDR_W registers of 8 bits
// RO_MASK  16'h0000 bit i set -> register i read-only from I2C (width REG_COUNT)
// PORTS
// clk          in   1       system clock, all flops on posedge
// reset        in   1       asynchronous, active-low reset
// start        in   1       1-cycle pulse: I2C start/restart addressed to this slave
// datareceive  in   8       byte from slave engine, stable while received=1
// received     in   1       level from slave engine, high after each received data byte
// sended       in   1       level from slave engine, high after each transmitted byte
// datasend     out  8       byte to transmit, registered copy of reg[ptr]
// host_addr    in   ADDR_W  host read/write address
// host_rdata   out  8       combinational reg[host_addr]
// host_we      in   1       host write enable
// host_wdata   in   8       host write data
// wr_strobe    out  1       1-cycle pulse: I2C write committed
// wr_addr      out  ADDR_W  address of committed I2C write
// wr_data      out  8       data of committed I2C write
// ptr          out  ADDR_W  current register pointer
// BEHAVIOUR
// - Reset (reset=0, async): all regs 8'h00, ptr=0, state=S_IDLE, datasend=8'h00,
//   wr_strobe=0, wr_addr=0, wr_data=0, edge-detect flops=0. Mid-transaction reset aborts it.
// - received/sended are multi-cycle levels: rx_rise = received & ~received_d,
//   tx_rise = sended & ~sended_d. Only rises act; a held level never repeats an action.
// - FSM: S_IDLE, S_PTR, S_DATA.
//   start (any state, top priority) -> S_PTR; ptr unchanged.
//   S_PTR + rx_rise: ptr <= datareceive[ADDR_W-1:0] (upper bits ignored) -> S_DATA.
//   S_DATA + rx_rise: if RO_MASK[ptr]=0, reg[ptr] <= datareceive and wr_strobe=1 next
//     cycle with wr_addr=ptr, wr_data=byte; if RO, no write, no strobe. ptr <= ptr+1 either way.
//   S_IDLE + rx_rise: ignored (no write, ptr unchanged).
//   tx_rise (any state): ptr <= ptr+1; state unchanged.
// - ptr wraps modulo REG_COUNT (2**ADDR_W-1 -> 0), for writes and reads.
// - datasend <= reg[ptr] every cycle (1-cycle latency from ptr/reg change); valid well
//   before the engine shifts the next byte's MSB.
// - start coincident with rx_rise/tx_rise: start wins, edge is dropped.
// - host_we=1 and I2C write to same address same cycle: I2C value wins; different
//   addresses: both commit. Host writes ignore RO_MASK and do not pulse wr_strobe.
// - host_rdata reflects a write the cycle after the committing edge.
// TESTING
// 1. Reset: regs, ptr, datasend, wr_* all 0 -> after start, datasend=8'h00, ptr=0.
// 2. start, bytes 8'h03,8'hA5,8'h5A -> reg3=A5, reg4=5A, ptr=5, two wr_strobe pulses.
// 3. received held 20 cycles per byte -> exactly one write per byte, one ptr step.
// 4. ptr=15 (ADDR_W=4), write 8'h11,8'h22 -> reg15=11, reg0=22, ptr=1 (wrap).
// 5. RO_MASK=16'h0004, write ptr 2 with 8'hFF -> reg2 unchanged, no wr_strobe, ptr=3.
// 6. host writes reg6=8'h77; start, ptr byte 6, restart, two sended rises -> datasend
//    77 then reg7, ptr=8; coincident start+received -> no write.

Source files
------------

// File: rtl/i2c_slave_regfile_if.sv
// Bundle of the I2C byte-engine handshake, the host port and the write-notify outputs.
interface i2c_slave_regfile_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic [7:0]        datareceive;
  logic              received;
  logic              sended;
  logic [7:0]        datasend;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_rdata;
  logic              host_we;
  logic [7:0]        host_wdata;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] ptr;

  // Register bank side
  modport slave (
    input  start, datareceive, received, sended,
    input  host_addr, host_we, host_wdata,
    output datasend, host_rdata, wr_strobe, wr_addr, wr_data, ptr
  );

  // Byte engine / user logic side
  modport master (
    output start, datareceive, received, sended,
    output host_addr, host_we, host_wdata,
    input  datasend, host_rdata, wr_strobe, wr_addr, wr_data, ptr
  );
endinterface

// File: rtl/i2c_slave_regfile.sv
// Register bank behind the I2C slave byte engine: first byte after start sets the
// pointer, later bytes write with auto-increment, transmitted bytes stream from the pointer.
module i2c_slave_regfile #(
  parameter int unsigned             ADDR_W  = 4,
  parameter logic [(2**ADDR_W)-1:0]  RO_MASK = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_slave_regfile_if.slave    bus
);

  localparam int unsigned REG_COUNT = 2**ADDR_W;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PTR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                received_d, sended_d;
  logic                rx_rise, tx_rise;
  logic                i2c_we_c;
  logic [DATA_W-1:0]   regs_q [REG_COUNT];
  logic [DATA_W-1:0]   datasend_q;
  logic                wr_strobe_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;

  assign rx_rise = bus.received & ~received_d;
  assign tx_rise = bus.sended & ~sended_d;

  // Edge-detect history for the engine's level handshakes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      received_d <= 1'b0;
      sended_d   <= 1'b0;
    end else begin
      received_d <= bus.received;
      sended_d   <= bus.sended;
    end
  end

  // State and pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state, pointer and write decision; start swallows any coincident edge
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    i2c_we_c = 1'b0;
    if (bus.start) begin
      state_d = S_PTR;
    end else if (rx_rise) begin
      case (state_q)
        S_PTR: begin
          ptr_d   = bus.datareceive[ADDR_W-1:0];
          state_d = S_DATA;
        end
        S_DATA: begin
          i2c_we_c = ~RO_MASK[ptr_q];
          ptr_d    = ptr_q + ADDR_W'(1);
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else if (tx_rise) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  // Register array; the I2C write is applied last so it wins an address collision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (bus.host_we) begin
        regs_q[bus.host_addr] <= bus.host_wdata;
      end
      if (i2c_we_c) begin
        regs_q[ptr_q] <= bus.datareceive;
      end
    end
  end

  // Committed-write notification and transmit byte staging
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      datasend_q  <= '0;
    end else begin
      wr_strobe_q <= i2c_we_c;
      if (i2c_we_c) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= bus.datareceive;
      end
      datasend_q <= regs_q[ptr_q];
    end
  end

  assign bus.datasend   = datasend_q;
  assign bus.host_rdata = regs_q[bus.host_addr];
  assign bus.wr_strobe  = wr_strobe_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.ptr        = ptr_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench: transaction-level model of the register bank, compared every cycle,
// plus literal expectations for each directed scenario.
module tb_i2c_slave_regfile;

  localparam int unsigned ADDR_W = 4;
  localparam logic [15:0] RO     = 16'h0004;

  logic clk;
  logic reset;

  i2c_slave_regfile_if #(.ADDR_W(ADDR_W)) bus ();

  i2c_slave_regfile #(
    .ADDR_W  (ADDR_W),
    .RO_MASK (RO)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  int dut_strobes;
  int exp_strobes;

  // Model state: registers, pointer, session phase (0 idle, 1 expect pointer, 2 data)
  logic [7:0] m_regs [16];
  logic [3:0] m_ptr;
  int         m_phase;
  logic       m_rx_prev, m_tx_prev;
  logic [7:0] m_ds;
  logic       m_strobe;
  logic [3:0] m_wa;
  logic [7:0] m_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 4'd0; m_phase = 0; m_rx_prev = 1'b0; m_tx_prev = 1'b0;
    m_ds = 8'h00; m_strobe = 1'b0; m_wa = 4'd0; m_wd = 8'h00;
  endtask

  // Apply the rules for one clock edge using the inputs the DUT just sampled
  task automatic model_edge();
    logic rx, tx;
    rx = bus.received & ~m_rx_prev;
    tx = bus.sended & ~m_tx_prev;
    m_rx_prev = bus.received;
    m_tx_prev = bus.sended;
    m_ds = m_regs[m_ptr];
    m_strobe = 1'b0;
    if (bus.host_we) m_regs[bus.host_addr] = bus.host_wdata;
    if (bus.start) begin
      m_phase = 1;
    end else if (rx) begin
      if (m_phase == 1) begin
        m_ptr = bus.datareceive[3:0];
        m_phase = 2;
      end else if (m_phase == 2) begin
        if (!RO[m_ptr]) begin
          m_regs[m_ptr] = bus.datareceive;
          m_strobe = 1'b1;
          m_wa = m_ptr;
          m_wd = bus.datareceive;
          exp_strobes++;
        end
        m_ptr = (m_ptr == 4'd15) ? 4'd0 : m_ptr + 4'd1;
      end
    end else if (tx) begin
      m_ptr = (m_ptr == 4'd15) ? 4'd0 : m_ptr + 4'd1;
    end
  endtask

  task automatic compare_all();
    check("ptr", 32'(bus.ptr), 32'(m_ptr));
    check("datasend", 32'(bus.datasend), 32'(m_ds));
    check("wr_strobe", 32'(bus.wr_strobe), 32'(m_strobe));
    if (m_strobe) begin
      check("wr_addr", 32'(bus.wr_addr), 32'(m_wa));
      check("wr_data", 32'(bus.wr_data), 32'(m_wd));
    end
    check("host_rdata", 32'(bus.host_rdata), 32'(m_regs[bus.host_addr]));
    if (bus.wr_strobe) dut_strobes++;
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input int hold);
    bus.datareceive = b;
    bus.received = 1'b1;
    repeat (hold) step();
    bus.received = 1'b0;
    idle(2);
  endtask

  task automatic rx_byte_host(input logic [7:0] b, input logic [3:0] ha, input logic [7:0] hd);
    bus.datareceive = b;
    bus.received = 1'b1;
    bus.host_addr = ha;
    bus.host_wdata = hd;
    bus.host_we = 1'b1;
    step();
    bus.host_we = 1'b0;
    step();
    bus.received = 1'b0;
    idle(2);
  endtask

  task automatic tx_byte(input int hold);
    bus.sended = 1'b1;
    repeat (hold) step();
    bus.sended = 1'b0;
    idle(2);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    bus.host_addr = a;
    bus.host_wdata = d;
    bus.host_we = 1'b1;
    step();
    bus.host_we = 1'b0;
  endtask

  task automatic host_read(input string name, input logic [3:0] a, input logic [7:0] exp);
    bus.host_addr = a;
    #1;
    check(name, 32'(bus.host_rdata), 32'(exp));
  endtask

  int s0;

  initial begin
    n_cmp = 0; n_bad = 0; dut_strobes = 0; exp_strobes = 0;
    model_reset();
    bus.start = 1'b0; bus.datareceive = 8'h00; bus.received = 1'b0; bus.sended = 1'b0;
    bus.host_addr = 4'd0; bus.host_we = 1'b0; bus.host_wdata = 8'h00;
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ptr", 32'(bus.ptr), 32'h0);
    check("rst_datasend", 32'(bus.datasend), 32'h0);
    check("rst_wr_strobe", 32'(bus.wr_strobe), 32'h0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'h0);
    check("rst_wr_data", 32'(bus.wr_data), 32'h0);
    for (int i = 0; i < 16; i++) host_read("rst_reg", 4'(i), 8'h00);
    reset = 1'b1;
    idle(2);
    pulse_start();
    idle(2);
    check("t1_datasend", 32'(bus.datasend), 32'h00);
    check("t1_ptr", 32'(bus.ptr), 32'h0);

    // Pointer byte then two writes
    s0 = dut_strobes;
    pulse_start();
    rx_byte(8'h03, 2);
    rx_byte(8'hA5, 2);
    rx_byte(8'h5A, 2);
    host_read("t2_reg3", 4'd3, 8'hA5);
    host_read("t2_reg4", 4'd4, 8'h5A);
    check("t2_ptr", 32'(bus.ptr), 32'd5);
    check("t2_strobes", 32'(dut_strobes - s0), 32'd2);

    // Long-held received level acts once per byte
    s0 = dut_strobes;
    pulse_start();
    rx_byte(8'h08, 20);
    rx_byte(8'hC1, 20);
    rx_byte(8'hC2, 20);
    rx_byte(8'hC3, 20);
    check("t3_ptr", 32'(bus.ptr), 32'd11);
    check("t3_strobes", 32'(dut_strobes - s0), 32'd3);
    host_read("t3_reg8", 4'd8, 8'hC1);
    host_read("t3_reg10", 4'd10, 8'hC3);

    // Pointer wrap on write
    pulse_start();
    rx_byte(8'hFF, 2);
    check("t4_ptr_upper_ignored", 32'(bus.ptr), 32'd15);
    rx_byte(8'h11, 2);
    rx_byte(8'h22, 2);
    host_read("t4_reg15", 4'd15, 8'h11);
    host_read("t4_reg0", 4'd0, 8'h22);
    check("t4_ptr", 32'(bus.ptr), 32'd1);

    // Read-only register
    s0 = dut_strobes;
    pulse_start();
    rx_byte(8'h02, 2);
    rx_byte(8'hFF, 2);
    host_read("t5_reg2", 4'd2, 8'h00);
    check("t5_strobes", 32'(dut_strobes - s0), 32'd0);
    check("t5_ptr", 32'(bus.ptr), 32'd3);

    // Host writes, then I2C read streaming with a restart
    host_write(4'd6, 8'h77);
    host_write(4'd7, 8'h88);
    pulse_start();
    rx_byte(8'h06, 2);
    pulse_start();
    idle(2);
    check("t6_datasend0", 32'(bus.datasend), 32'h77);
    tx_byte(3);
    check("t6_ptr7", 32'(bus.ptr), 32'd7);
    check("t6_datasend1", 32'(bus.datasend), 32'h88);
    tx_byte(3);
    check("t6_ptr8", 32'(bus.ptr), 32'd8);

    // Start coincident with received: edge dropped, next byte is a pointer
    s0 = dut_strobes;
    bus.datareceive = 8'h99;
    bus.received = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    idle(2);
    bus.received = 1'b0;
    idle(2);
    check("t6_coinc_ptr", 32'(bus.ptr), 32'd8);
    check("t6_coinc_strobes", 32'(dut_strobes - s0), 32'd0);
    host_read("t6_coinc_reg8", 4'd8, 8'hC1);
    rx_byte(8'h03, 2);
    check("t6_ptr_after", 32'(bus.ptr), 32'd3);
    check("t6_coinc_nostrobe", 32'(dut_strobes - s0), 32'd0);

    // Host and I2C writes in the same cycle
    pulse_start();
    rx_byte(8'h0C, 2);
    rx_byte_host(8'hAB, 4'd12, 8'h55);
    rx_byte_host(8'hCD, 4'd1, 8'h66);
    host_read("t7_reg12", 4'd12, 8'hAB);
    host_read("t7_reg13", 4'd13, 8'hCD);
    host_read("t7_reg1", 4'd1, 8'h66);
    check("t7_ptr", 32'(bus.ptr), 32'd14);

    check("total_strobes", 32'(dut_strobes), 32'(exp_strobes));
    check("total_strobes_lit", 32'(dut_strobes), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
